// File: rtl/airlock_pkg.sv
// airlock_pkg
// Shared definitions for the airlock sequencer and the downstream
// door-command decoder.
//   - CMD_* : 3-bit door command encoding (111 is never driven)
//   - state_t : sequencer state encoding
//   - state_cmd() : the door command each state drives
//   - is_pump_state() : states whose step length is the pump time
package airlock_pkg;

    localparam logic [2:0] CMD_IDLE         = 3'b000;
    localparam logic [2:0] CMD_CLOSE_INNER  = 3'b001;
    localparam logic [2:0] CMD_OPEN_INNER   = 3'b010;
    localparam logic [2:0] CMD_CLOSE_OUTER  = 3'b011;
    localparam logic [2:0] CMD_OPEN_OUTER   = 3'b100;
    localparam logic [2:0] CMD_DEPRESSURIZE = 3'b101;
    localparam logic [2:0] CMD_PRESSURIZE   = 3'b110;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_OPEN_IN   = 4'd1,
        S_WAIT_IN   = 4'd2,
        S_CLOSE_IN  = 4'd3,
        S_DEPRESS   = 4'd4,
        S_OPEN_OUT  = 4'd5,
        S_WAIT_OUT  = 4'd6,
        S_CLOSE_OUT = 4'd7,
        S_PRESS     = 4'd8
    } state_t;

    function automatic logic [2:0] state_cmd(input state_t s);
        logic [2:0] c;
        c = CMD_IDLE;
        case (s)
            S_OPEN_IN,  S_WAIT_IN:  c = CMD_OPEN_INNER;
            S_CLOSE_IN:             c = CMD_CLOSE_INNER;
            S_DEPRESS:              c = CMD_DEPRESSURIZE;
            S_OPEN_OUT, S_WAIT_OUT: c = CMD_OPEN_OUTER;
            S_CLOSE_OUT:            c = CMD_CLOSE_OUTER;
            S_PRESS:                c = CMD_PRESSURIZE;
            default:                c = CMD_IDLE;
        endcase
        return c;
    endfunction

    function automatic logic is_pump_state(input state_t s);
        return (s == S_DEPRESS) || (s == S_PRESS);
    endfunction

endpackage

// File: rtl/airlock_sequencer_if.sv
// airlock_sequencer_if
// Occupant-side request/confirm inputs and door-side status outputs of
// the airlock sequencer.
//   req_enter, req_exit : trip requests, sampled only while idle
//   confirm             : occupant has passed the open door (1-cycle pulse)
//   cmd                 : registered 3-bit door command
//   busy, chamber_vac, done : status flags
//   state_dbg           : current sequencer state, for observation only
//
// Handshake: there is no ready/ack. A request is taken on the rising edge
// where it is high and the sequencer is idle; otherwise it is dropped, not
// queued. confirm is taken only on an edge inside a wait-for-occupant state
// and ignored everywhere else. The slave modport is the sequencer side.
interface airlock_sequencer_if;
    import airlock_pkg::*;

    logic       req_enter;
    logic       req_exit;
    logic       confirm;
    logic [2:0] cmd;
    logic       busy;
    logic       chamber_vac;
    logic       done;
    state_t     state_dbg;

    modport master (
        output req_enter, req_exit, confirm,
        input  cmd, busy, chamber_vac, done, state_dbg
    );

    modport slave (
        input  req_enter, req_exit, confirm,
        output cmd, busy, chamber_vac, done, state_dbg
    );

endinterface

// File: rtl/airlock_sequencer_step_timer.sv
// step_timer
// Cycle counter for the timed steps of the airlock sequence.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the count at 0 on the next edge
//   length     : step length in cycles (>= 1); one bit wider than the
//                counter so that length == 2^CNT_W is representable
//   expire     : high in the last cycle of a step (cnt == length-1)
module step_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W:0]   length,
    output logic             expire
);

    localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = ({1'b0, cnt} == (length - ONE));

endmodule

// File: rtl/airlock_sequencer.sv
// airlock_sequencer
// Sequences a two-door airlock through open / close / pump steps for
// enter (outside -> inside) and exit (inside -> outside) trips. The chamber
// rests pressurized with both doors closed between trips.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset, forces idle immediately
//   bus   : airlock_sequencer_if.slave (requests, confirm, cmd, status)
// Parameters: DOOR_CYCLES / PUMP_CYCLES step lengths in cycles,
// CNT_W step counter width (2^CNT_W >= max step length).
module airlock_sequencer
    import airlock_pkg::*;
#(
    parameter int DOOR_CYCLES = 8,
    parameter int PUMP_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    airlock_sequencer_if.slave   bus
);

    localparam logic [CNT_W:0] DOOR_LEN = (CNT_W+1)'(DOOR_CYCLES);
    localparam logic [CNT_W:0] PUMP_LEN = (CNT_W+1)'(PUMP_CYCLES);

    state_t         state, state_n;
    logic           dir, dir_n;      // 0 = exit trip, 1 = enter trip
    logic           vac, vac_n;
    logic           done_n;
    logic [2:0]     cmd_q;
    logic           busy_q;
    logic           done_q;

    logic           expire;
    logic           clear;
    logic [CNT_W:0] length;

    // Restarting the count on every state change gives each timed state a
    // fresh count on entry; wait/idle states never look at expire.
    assign clear  = (state_n != state);
    assign length = is_pump_state(state) ? PUMP_LEN : DOOR_LEN;

    step_timer #(.CNT_W(CNT_W)) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .length (length),
        .expire (expire)
    );

    // Outputs are computed from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            dir    <= 1'b0;
            vac    <= 1'b0;
            cmd_q  <= CMD_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            dir    <= dir_n;
            vac    <= vac_n;
            cmd_q  <= state_cmd(state_n);
            busy_q <= (state_n != S_IDLE);
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = dir;
        vac_n   = vac;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                // Exit wins when both requests arrive together.
                if (bus.req_exit) begin
                    state_n = S_OPEN_IN;
                    dir_n   = 1'b0;
                end else if (bus.req_enter) begin
                    state_n = S_DEPRESS;
                    dir_n   = 1'b1;
                end
            end
            S_OPEN_IN:   if (expire)      state_n = S_WAIT_IN;
            S_WAIT_IN:   if (bus.confirm) state_n = S_CLOSE_IN;
            S_CLOSE_IN: begin
                if (expire) begin
                    if (dir) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_DEPRESS;
                    end
                end
            end
            S_DEPRESS: begin
                if (expire) begin
                    state_n = S_OPEN_OUT;
                    vac_n   = 1'b1;
                end
            end
            S_OPEN_OUT:  if (expire)      state_n = S_WAIT_OUT;
            S_WAIT_OUT:  if (bus.confirm) state_n = S_CLOSE_OUT;
            S_CLOSE_OUT: if (expire)      state_n = S_PRESS;
            S_PRESS: begin
                if (expire) begin
                    vac_n = 1'b0;
                    if (dir) begin
                        state_n = S_OPEN_IN;
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                // Unreachable encodings: back to a safe idle, no done pulse.
                state_n = S_IDLE;
                vac_n   = 1'b0;
            end
        endcase
    end

    assign bus.cmd         = cmd_q;
    assign bus.busy        = busy_q;
    assign bus.chamber_vac = vac;
    assign bus.done        = done_q;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_airlock_sequencer.sv
// tb_airlock_sequencer
// Bench for airlock_sequencer with DOOR_CYCLES=4, PUMP_CYCLES=6.
// Each trip is described as a list of door-command segments; the list is
// expanded into a per-cycle expected queue of {cmd, busy, chamber_vac, done}
// plus the confirm value to drive in that cycle.
module tb_airlock_sequencer;
    import airlock_pkg::*;

    localparam int DOOR = 4;
    localparam int PUMP = 6;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    airlock_sequencer_if bus();

    airlock_sequencer #(
        .DOOR_CYCLES (DOOR),
        .PUMP_CYCLES (PUMP),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] exp_q[$];
    bit         conf_q[$];

    task automatic check_val(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got={cmd,busy,vac,done}=%b required=%b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] observed();
        return {bus.cmd, bus.busy, bus.chamber_vac, bus.done};
    endfunction

    // ---------------- reference model ----------------
    // One segment = a command held for len cycles. A wait segment ends
    // because confirm is driven in its last cycle; elsewhere confirm is
    // noise that must be ignored.
    task automatic push_seg(input logic [2:0] cmd, input int len, input bit vac,
                            input bit is_wait, input bit noise);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({cmd, 1'b1, vac, 1'b0});
            if (is_wait) conf_q.push_back(i == len - 1);
            else         conf_q.push_back(noise ? 1'($urandom_range(0, 1)) : 1'b0);
        end
    endtask

    task automatic build_trip(input bit exit_path, input int w_in, input int w_out, input bit noise);
        exp_q.delete();
        conf_q.delete();
        if (exit_path) begin
            push_seg(3'b010, DOOR,  1'b0, 1'b0, noise);
            push_seg(3'b010, w_in,  1'b0, 1'b1, noise);
            push_seg(3'b001, DOOR,  1'b0, 1'b0, noise);
            push_seg(3'b101, PUMP,  1'b0, 1'b0, noise);
            push_seg(3'b100, DOOR,  1'b1, 1'b0, noise);
            push_seg(3'b100, w_out, 1'b1, 1'b1, noise);
            push_seg(3'b011, DOOR,  1'b1, 1'b0, noise);
            push_seg(3'b110, PUMP,  1'b1, 1'b0, noise);
        end else begin
            push_seg(3'b101, PUMP,  1'b0, 1'b0, noise);
            push_seg(3'b100, DOOR,  1'b1, 1'b0, noise);
            push_seg(3'b100, w_out, 1'b1, 1'b1, noise);
            push_seg(3'b011, DOOR,  1'b1, 1'b0, noise);
            push_seg(3'b110, PUMP,  1'b1, 1'b0, noise);
            push_seg(3'b010, DOOR,  1'b0, 1'b0, noise);
            push_seg(3'b010, w_in,  1'b0, 1'b1, noise);
            push_seg(3'b001, DOOR,  1'b0, 1'b0, noise);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge with the DUT idle. Issues the request, checks every
    // trip cycle and the done cycle. abort_at > 0 asserts reset between
    // edges after that many trip cycles and checks the immediate clear.
    task automatic run_trip(input string name, input bit exit_path, input int w_in,
                            input int w_out, input bit noise, input bit hold_enter,
                            input int abort_at);
        int n;
        build_trip(exit_path, w_in, w_out, noise);
        n = exp_q.size();
        bus.req_exit  = exit_path;
        bus.req_enter = !exit_path || hold_enter;
        bus.confirm   = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_val($sformatf("%s_c%0d", name, i), observed(), exp_q.pop_front());
            bus.confirm   = conf_q.pop_front();
            bus.req_exit  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.req_enter = hold_enter ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            if (abort_at == i + 1) begin
                #2 reset = 1'b1;
                #1 check_val($sformatf("%s_async_reset", name), observed(), 6'b000_0_0_0);
                bus.req_exit  = 1'b0;
                bus.req_enter = 1'b0;
                bus.confirm   = 1'b0;
                @(negedge clk);
                check_val($sformatf("%s_in_reset", name), observed(), 6'b000_0_0_0);
                reset = 1'b0;
                return;
            end
        end
        @(negedge clk);
        check_val($sformatf("%s_done", name), observed(), 6'b000_0_0_1);
        bus.confirm   = 1'b0;
        bus.req_exit  = 1'b0;
        bus.req_enter = hold_enter;
    endtask

    task automatic idle_cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_val($sformatf("%s_idle%0d", name, i), observed(), 6'b000_0_0_0);
            bus.confirm = 1'($urandom_range(0, 1));
        end
        bus.confirm = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.req_enter = 1'b0;
        bus.req_exit  = 1'b0;
        bus.confirm   = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_state", observed(), 6'b000_0_0_0);
        reset = 1'b0;
        idle_cycles("post_reset", 20);

        run_trip("exit", 1'b1, 3, 3, 1'b0, 1'b0, 0);
        idle_cycles("after_exit", 2);

        run_trip("enter", 1'b0, 1, 1, 1'b0, 1'b0, 0);
        idle_cycles("after_enter", 2);

        // Both requests together: exit path, then the held enter request
        // starts a new trip the cycle after done.
        run_trip("both_req", 1'b1, 2, 4, 1'b0, 1'b1, 0);
        run_trip("held_enter", 1'b0, 2, 2, 1'b0, 1'b0, 0);
        idle_cycles("after_held", 2);

        // Long wait in S_WAIT_OUT with random requests/confirm noise elsewhere.
        run_trip("long_wait", 1'b1, 2, 100, 1'b1, 1'b0, 0);
        idle_cycles("after_long", 2);

        // Abort in S_DEPRESS of an exit trip, then restart cleanly.
        run_trip("abort_dep", 1'b1, 2, 2, 1'b0, 1'b0, 2 * DOOR + 2 + 3);
        idle_cycles("after_abort_dep", 3);
        run_trip("restart", 1'b1, 2, 2, 1'b0, 1'b0, 0);
        idle_cycles("after_restart", 2);

        // Abort while the chamber is at vacuum.
        run_trip("abort_vac", 1'b0, 1, 3, 1'b0, 1'b0, PUMP + 3);
        idle_cycles("after_abort_vac", 3);

        for (int t = 0; t < 6; t++) begin
            run_trip($sformatf("rand%0d", t), 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, 8)), int'($urandom_range(1, 8)),
                     1'b1, 1'b0, 0);
            idle_cycles($sformatf("rand%0d", t), int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
